// File: rtl/bk_adder_pkg.sv
// Shared constants, operand record and adder-bus packing for the shared
// Brent-Kung adder arbiter.
package bk_adder_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 12;
    localparam int unsigned IDW  = $clog2(NREQ);

    typedef struct packed {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [IDW-1:0] id;
    } op_t;

    // The adder expects operand bits interleaved: bit 2k = a[k], bit 2k+1 = b[k].
    function automatic logic [2*W-1:0] interleave(input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        logic [2*W-1:0] bus;
        bus = '0;
        for (int unsigned k = 0; k < W; k++) begin
            bus[2*k]   = a[k];
            bus[2*k+1] = b[k];
        end
        return bus;
    endfunction

endpackage

// File: rtl/bk_adder_share_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    int unsigned j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (en && !any && req[j]) begin
                any     = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/bk_adder_share_arbiter.sv
// Round-robin sharing of one external combinational adder among NREQ
// requesters, with an operand stage feeding the adder and a result stage.
module bk_adder_share_arbiter
    import bk_adder_pkg::*;
#(
    parameter int unsigned NREQ = bk_adder_pkg::NREQ,
    parameter int unsigned W    = bk_adder_pkg::W,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [2*W-1:0]    add_in,
    input  logic [W:0]        add_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W:0]        rsp_sum,
    output logic [IDW-1:0]    rsp_id
);

    logic            adv1;
    logic            adv2;
    logic            s1_valid;
    op_t             s1;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  ptr_next;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;

    assign adv2 = !rsp_valid || rsp_ready;
    assign adv1 = !s1_valid || adv2;

    rr_arbiter #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .en     (adv1),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .any    (gnt_any)
    );

    assign req_ready = gnt;
    assign add_in    = interleave(s1.a, s1.b);
    assign ptr_next  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    // Operands load only on a grant so add_in stays quiet through idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1        <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= gnt_any;
                if (gnt_any) begin
                    s1     <= '{a: sel_a, b: sel_b, id: gnt_idx};
                    rr_ptr <= ptr_next;
                end
            end
            if (adv2) begin
                rsp_valid <= s1_valid;
                rsp_sum   <= add_out;
                rsp_id    <= s1.id;
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_hold_chk
        a_operand_hold : assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid[i] && !req_ready[i]) |=>
            (!req_valid[i] || ($stable(req_a[i*W +: W]) && $stable(req_b[i*W +: W]))));
    end

endmodule

// File: tb/tb_bk_adder_share_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the two-stage shared-adder pipeline.
module tb_bk_adder_share_arbiter;

    localparam int NR = 4;
    localparam int WD = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*WD-1:0] req_a;
    logic [NR*WD-1:0] req_b;
    logic [NR-1:0]    req_ready;
    logic [2*WD-1:0]  add_in;
    logic [WD:0]      add_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WD:0]      rsp_sum;
    logic [1:0]       rsp_id;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    bit        m_s1v, m_rv;
    logic [WD:0] m_s1sum, m_rsum;
    int        m_s1id, m_rid, m_ptr, last_gnt;

    logic [WD-1:0] ad_x, ad_y;

    always #5 clk = ~clk;

    // External adder stand-in: de-interleave and add.
    always_comb begin
        ad_x = '0;
        ad_y = '0;
        for (int k = 0; k < WD; k++) begin
            ad_x[k] = add_in[2*k];
            ad_y[k] = add_in[2*k+1];
        end
        add_out = {1'b0, ad_x} + {1'b0, ad_y};
    end

    bk_adder_share_arbiter #(.NREQ(NR), .W(WD), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .add_in(add_in), .add_out(add_out), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id)
    );

    function automatic logic [NR-1:0] exp_ready();
        logic [NR-1:0] r;
        bit a1, a2;
        r  = '0;
        a2 = !m_rv || rsp_ready;
        a1 = !m_s1v || a2;
        if (a1) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (m_ptr + k) % NR;
                if (req_valid[j] && r == '0) r[j] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        m_s1v = 0; m_rv = 0; m_s1sum = '0; m_rsum = '0;
        m_s1id = 0; m_rid = 0; m_ptr = 0; last_gnt = -1;
    endtask

    task automatic tick();
        logic [NR-1:0] r;
        bit a1, a2;
        int g;
        logic [WD:0] s;
        a2 = !m_rv || rsp_ready;
        a1 = !m_s1v || a2;
        r  = exp_ready();
        g  = -1;
        s  = '0;
        for (int i = 0; i < NR; i++) if (r[i]) g = i;
        if (g >= 0) s = {1'b0, req_a[g*WD +: WD]} + {1'b0, req_b[g*WD +: WD]};
        @(posedge clk);
        if (a2) begin m_rv = m_s1v; m_rsum = m_s1sum; m_rid = m_s1id; end
        if (a1) begin
            m_s1v = (g >= 0);
            if (g >= 0) begin m_s1sum = s; m_s1id = g; m_ptr = (g + 1) % NR; end
        end
        last_gnt = g;
        #1;
    endtask

    task automatic pulse_reset();
        req_valid = '0;
        rst_n = 1'b0;
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_sum !== 13'h0) begin n_err++; $display("FAIL reset_rsp_sum got=%h exp=0", rsp_sum); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        n_cmp++; if (add_in !== 24'h0) begin n_err++; $display("FAIL reset_add_in got=%h exp=0", add_in); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req_a[0 +: WD] = 12'hFFF; req_b[0 +: WD] = 12'h001;
        req_valid = 4'b0001; rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0; #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_t1_valid got=%b exp=0", rsp_valid); end
        tick(); #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_t2_valid got=%b exp=1", rsp_valid); end
        n_cmp++; if (rsp_sum !== 13'h1000) begin n_err++; $display("FAIL single_sum got=%h exp=1000", rsp_sum); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL single_id got=%0d exp=0", rsp_id); end
        tick(); #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_t3_valid got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        pulse_reset();
        for (int i = 0; i < NR; i++) begin
            req_a[i*WD +: WD] = 12'(i);
            req_b[i*WD +: WD] = 12'(10 * i);
        end
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) req_valid = '0;
            #1;
            if (c < 5) begin
                n_cmp++; if (req_ready !== 4'(1 << order[c])) begin n_err++; $display("FAIL rr_grant c=%0d got=%b exp=%0d", c, req_ready, order[c]); end
            end
            if (c >= 2) begin
                n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid c=%0d got=%b exp=1", c, rsp_valid); end
                n_cmp++; if (rsp_sum !== 13'(11 * order[c-2])) begin n_err++; $display("FAIL rr_sum c=%0d got=%0d exp=%0d", c, rsp_sum, 11 * order[c-2]); end
                n_cmp++; if (rsp_id !== 2'(order[c-2])) begin n_err++; $display("FAIL rr_id c=%0d got=%0d exp=%0d", c, rsp_id, order[c-2]); end
            end else begin
                n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_early_valid c=%0d got=%b exp=0", c, rsp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int ngr;
        logic [WD:0]     hold_sum;
        logic [1:0]      hold_id;
        logic [2*WD-1:0] hold_add;
        logic [WD:0]     s0, s1;
        pulse_reset();
        for (int i = 0; i < NR; i++) begin
            req_a[i*WD +: WD] = 12'($urandom);
            req_b[i*WD +: WD] = 12'($urandom);
        end
        s0 = {1'b0, req_a[0 +: WD]} + {1'b0, req_b[0 +: WD]};
        s1 = {1'b0, req_a[WD +: WD]} + {1'b0, req_b[WD +: WD]};
        req_valid = 4'b1111; rsp_ready = 1'b0;
        ngr = 0; hold_sum = '0; hold_id = '0; hold_add = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            ngr += $countones(req_valid & req_ready);
            if (c >= 2) begin
                n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_no_grant c=%0d got=%b exp=0000", c, req_ready); end
            end
            if (c == 2) begin
                hold_sum = rsp_sum; hold_id = rsp_id; hold_add = add_in;
                n_cmp++; if (rsp_sum !== s0) begin n_err++; $display("FAIL bp_head_sum got=%h exp=%h", rsp_sum, s0); end
            end
            if (c > 2) begin
                n_cmp++; if (rsp_sum !== hold_sum || rsp_id !== hold_id) begin n_err++; $display("FAIL bp_rsp_stable got=%h/%0d exp=%h/%0d", rsp_sum, rsp_id, hold_sum, hold_id); end
                n_cmp++; if (add_in !== hold_add) begin n_err++; $display("FAIL bp_add_in_stable got=%h exp=%h", add_in, hold_add); end
            end
            tick();
        end
        n_cmp++; if (ngr !== 2) begin n_err++; $display("FAIL bp_grant_count got=%0d exp=2", ngr); end
        req_valid = '0; rsp_ready = 1'b1; #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_sum !== s0 || rsp_id !== 2'd0) begin n_err++; $display("FAIL bp_release0 got=%b/%h/%0d exp=1/%h/0", rsp_valid, rsp_sum, rsp_id, s0); end
        tick(); #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_sum !== s1 || rsp_id !== 2'd1) begin n_err++; $display("FAIL bp_release1 got=%b/%h/%0d exp=1/%h/1", rsp_valid, rsp_sum, rsp_id, s1); end
        tick(); #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_end got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_pointer_skip();
        pulse_reset();
        rsp_ready = 1'b1;
        req_a[0 +: WD] = 12'($urandom); req_b[0 +: WD] = 12'($urandom);
        req_valid = 4'b0001; #1;
        tick();
        req_a[3*WD +: WD] = 12'($urandom); req_b[3*WD +: WD] = 12'($urandom);
        req_valid = 4'b1001; #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL skip_grant3 got=%b exp=1000", req_ready); end
        tick(); #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL skip_wrap0 got=%b exp=0001", req_ready); end
        tick(); #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL skip_ptr1 got=%b exp=1000", req_ready); end
        tick();
        req_valid = '0;
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic test_reset_midflight();
        pulse_reset();
        req_a[WD +: WD] = 12'($urandom); req_b[WD +: WD] = 12'($urandom);
        req_a[2*WD +: WD] = 12'($urandom); req_b[2*WD +: WD] = 12'($urandom);
        req_valid = 4'b0110; rsp_ready = 1'b0; #1;
        tick(); tick(); #1;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin n_err++; $display("FAIL mid_full got=%b/%0d exp=1/1", rsp_valid, rsp_id); end
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_drop got=%b exp=0", rsp_valid); end
        req_valid = 4'b1111;
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0; rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic test_random();
        int waits [NR];
        logic [NR-1:0] er;
        pulse_reset();
        for (int i = 0; i < NR; i++) waits[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && last_gnt == i) begin
                    if ($urandom_range(1) == 0) req_valid[i] = 1'b0;
                    req_a[i*WD +: WD] = 12'($urandom);
                    req_b[i*WD +: WD] = 12'($urandom);
                end else if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_a[i*WD +: WD] = 12'($urandom);
                    req_b[i*WD +: WD] = 12'($urandom);
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            er = exp_ready();
            n_cmp++; if (req_ready !== er) begin n_err++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er); end
            n_cmp++; if (rsp_valid !== m_rv) begin n_err++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, m_rv); end
            if (m_rv) begin
                n_cmp++; if (rsp_sum !== m_rsum || rsp_id !== 2'(m_rid)) begin n_err++; $display("FAIL rand_rsp cyc=%0d got=%h/%0d exp=%h/%0d", cyc, rsp_sum, rsp_id, m_rsum, m_rid); end
            end
            if (er != '0) begin
                for (int i = 0; i < NR; i++) begin
                    if (er[i]) begin
                        n_cmp++; if (waits[i] > NR) begin n_err++; $display("FAIL rand_fair req=%0d got=%0d exp<=%0d", i, waits[i], NR); end
                        waits[i] = 0;
                    end else if (req_valid[i]) begin
                        waits[i]++;
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached, got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_pointer_skip();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
